// File: rtl/quad_encoder_gen_if.sv
// Request/status bundle of the quadrature encoder emulator.
// LW must equal $clog2(DEPTH)+1 of the attached quad_encoder_gen.
interface quad_encoder_gen_if #(
    parameter int LW = 3
);
    logic          L_pulse;
    logic          R_pulse;
    logic          press_req;
    logic          key_a;
    logic          key_b;
    logic          key_o;
    logic          busy;
    logic          overflow;
    logic [LW-1:0] level;

    modport master (
        output L_pulse, R_pulse, press_req,
        input  key_a, key_b, key_o, busy, overflow, level
    );

    modport slave (
        input  L_pulse, R_pulse, press_req,
        output key_a, key_b, key_o, busy, overflow, level
    );
endinterface

// File: rtl/quad_encoder_gen.sv
// EC11 rotary encoder + push-button emulator with a step-request FIFO.
// Define QGEN_BOUNCE_EN to add 7-cycle contact bounce on every edge.
module quad_encoder_gen #(
    parameter int DWELL     = 12000,
    parameter int DEPTH     = 4,
    parameter int PRESS_CYC = 120000
) (
    input logic              clk,
    input logic              rst,
    quad_encoder_gen_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int PW = $clog2(PRESS_CYC + 1);

    typedef enum logic [2:0] {IDLE, PH1, PH2, PH3, PH4, GAP} seq_t;
    typedef enum logic {P_IDLE, P_HOLD} prs_t;

    logic l_q, r_q, p_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            l_q <= 1'b0;
            r_q <= 1'b0;
            p_q <= 1'b0;
        end else begin
            l_q <= bus.L_pulse;
            r_q <= bus.R_pulse;
            p_q <= bus.press_req;
        end
    end

    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [LW-1:0]    level_q;
    logic             ovf_q;
    logic             pop, push, full, req_one, req_both;

    assign full     = (level_q == LW'(DEPTH));
    assign req_one  = l_q ^ r_q;
    assign req_both = l_q & r_q;
    assign push     = req_one && (!full || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= r_q;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                level_q <= level_q + 1'b1;
            else if (!push && pop)
                level_q <= level_q - 1'b1;
            ovf_q <= req_both | (req_one & full & ~pop);
        end
    end

    seq_t        state, state_n;
    logic [15:0] cnt;
    logic        dir;
    logic [1:0]  ab;
    logic        busy_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            dir   <= 1'b0;
        end else begin
            state <= state_n;
            if (pop)
                dir <= mem[rd_ptr];
            if (state_n != state)
                cnt <= 16'(DWELL - 1);
            else if (cnt != 16'd0)
                cnt <= cnt - 16'd1;
        end
    end

    // GAP chains straight into PH1 so queued steps run every 5*DWELL.
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        unique case (state)
            IDLE: begin
                if (level_q != '0) begin
                    pop     = 1'b1;
                    state_n = PH1;
                end
            end
            PH1: if (cnt == 16'd0) state_n = PH2;
            PH2: if (cnt == 16'd0) state_n = PH3;
            PH3: if (cnt == 16'd0) state_n = PH4;
            PH4: if (cnt == 16'd0) state_n = GAP;
            GAP: begin
                if (cnt == 16'd0) begin
                    if (level_q != '0) begin
                        pop     = 1'b1;
                        state_n = PH1;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // ab = {A, B}; dir=1 is clockwise (A leads).
    always_comb begin
        ab = 2'b11;
        unique case (state)
            PH1:     ab = dir ? 2'b01 : 2'b10;
            PH2:     ab = 2'b00;
            PH3:     ab = dir ? 2'b10 : 2'b01;
            default: ab = 2'b11;
        endcase
        busy_c = (state != IDLE) || (level_q != '0);
    end

    prs_t          pst, pst_n;
    logic [PW-1:0] pcnt;
    logic          key_t;

    always_ff @(posedge clk) begin
        if (rst) begin
            pst  <= P_IDLE;
            pcnt <= '0;
        end else begin
            pst <= pst_n;
            if (pst == P_IDLE && pst_n == P_HOLD)
                pcnt <= PW'(PRESS_CYC - 1);
            else if (pcnt != '0)
                pcnt <= pcnt - 1'b1;
        end
    end

    always_comb begin
        pst_n = pst;
        unique case (pst)
            P_IDLE:  if (p_q) pst_n = P_HOLD;
            P_HOLD:  if (pcnt == '0) pst_n = P_IDLE;
            default: pst_n = P_IDLE;
        endcase
    end

    always_comb begin
        key_t = (pst != P_HOLD);
    end

`ifdef QGEN_BOUNCE_EN
    logic [1:0] last_ab, chg_ab;
    logic       last_o;
    logic [2:0] sb, pb;

    // Odd counter values show the old level: new,old,...,new over 7 cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_ab <= 2'b11;
            chg_ab  <= 2'b00;
            last_o  <= 1'b1;
            sb      <= '0;
            pb      <= '0;
        end else begin
            last_ab <= ab;
            last_o  <= key_t;
            if (ab != last_ab) begin
                sb     <= 3'd5;
                chg_ab <= ab ^ last_ab;
            end else if (sb != 3'd0) begin
                sb <= sb - 3'd1;
            end
            if (key_t != last_o)
                pb <= 3'd5;
            else if (pb != 3'd0)
                pb <= pb - 3'd1;
        end
    end

    assign bus.key_a = ab[1] ^ (chg_ab[1] & sb[0]);
    assign bus.key_b = ab[0] ^ (chg_ab[0] & sb[0]);
    assign bus.key_o = key_t ^ pb[0];
`else
    assign bus.key_a = ab[1];
    assign bus.key_b = ab[0];
    assign bus.key_o = key_t;
`endif

    assign bus.busy     = busy_c;
    assign bus.overflow = ovf_q;
    assign bus.level    = level_q;
endmodule
